// File: rtl/idelay_ctrl_seq.sv
// Purpose: bring-up and supervision sequencer for IDELAYCTRL (reset pulse, RDY wait with retries, settle, loss recovery).
// Latency: dly_rst pulse of RST_CYCLES; ready rises SETTLE_CYCLES+3 edges after a stable dly_rdy rise, falls 3 edges after it drops.
// Backpressure: none; restart is a one-cycle request that overrides every state, dly_rdy is sampled through a 2-flop synchronizer.
module idelay_ctrl_seq #(
  parameter int RST_CYCLES    = 16,
  parameter int WAIT_CYCLES   = 4096,
  parameter int SETTLE_CYCLES = 32,
  parameter int MAX_RETRIES   = 3
) (
  input  logic       refclk,
  input  logic       rst,
  input  logic       restart,
  input  logic       dly_rdy,
  output logic       dly_rst,
  output logic       ready,
  output logic       fail,
  output logic       lost,
  output logic [3:0] retries
);

  localparam int MAX_RW = (RST_CYCLES > WAIT_CYCLES) ? RST_CYCLES : WAIT_CYCLES;
  localparam int MAX_C  = (MAX_RW > SETTLE_CYCLES) ? MAX_RW : SETTLE_CYCLES;
  localparam int CW     = $clog2(MAX_C) + 1;

  // Terminal counts: a phase of N cycles ends on the edge where the counter holds N-1.
  localparam logic [CW-1:0] RST_LAST    = CW'(RST_CYCLES - 1);
  localparam logic [CW-1:0] WAIT_LAST   = CW'(WAIT_CYCLES - 1);
  localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES - 1);
  localparam logic [3:0]    MAX_R       = 4'(MAX_RETRIES);

  typedef enum logic [2:0] {
    S_RESET_PULSE,
    S_WAIT_RDY,
    S_SETTLE,
    S_READY,
    S_FAILED
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [1:0]      sync_q;
  logic            rdy_s;
  logic            dly_rst_q, dly_rst_d;
  logic            ready_q, ready_d;
  logic            fail_q, fail_d;
  logic            lost_q, lost_d;
  logic [3:0]      retries_q, retries_d;

  assign rdy_s   = sync_q[1];
  assign dly_rst = dly_rst_q;
  assign ready   = ready_q;
  assign fail    = fail_q;
  assign lost    = lost_q;
  assign retries = retries_q;

  // Bring dly_rdy into the refclk domain.
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) sync_q <= 2'b00;
    else     sync_q <= {sync_q[0], dly_rdy};
  end

  // Next-state and next-output logic; restart overrides every transition.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    dly_rst_d = dly_rst_q;
    ready_d   = ready_q;
    fail_d    = fail_q;
    lost_d    = lost_q;
    retries_d = retries_q;
    if (restart) begin
      state_d   = S_RESET_PULSE;
      cnt_d     = '0;
      dly_rst_d = 1'b1;
      ready_d   = 1'b0;
      fail_d    = 1'b0;
      lost_d    = 1'b0;
      retries_d = 4'd0;
    end else begin
      case (state_q)
        S_RESET_PULSE: begin
          if (cnt_q == RST_LAST) begin
            state_d   = S_WAIT_RDY;
            cnt_d     = '0;
            dly_rst_d = 1'b0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        S_WAIT_RDY: begin
          // A rising RDY beats a coincident timeout.
          if (rdy_s) begin
            state_d = S_SETTLE;
            cnt_d   = '0;
          end else if (cnt_q == WAIT_LAST) begin
            cnt_d = '0;
            if (retries_q == MAX_R) begin
              state_d = S_FAILED;
              fail_d  = 1'b1;
            end else begin
              state_d   = S_RESET_PULSE;
              retries_d = retries_q + 4'd1;
              dly_rst_d = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        S_SETTLE: begin
          if (!rdy_s) begin
            state_d = S_WAIT_RDY;
            cnt_d   = '0;
          end else if (cnt_q == SETTLE_LAST) begin
            state_d = S_READY;
            cnt_d   = '0;
            ready_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        S_READY: begin
          if (!rdy_s) begin
            state_d   = S_RESET_PULSE;
            cnt_d     = '0;
            ready_d   = 1'b0;
            lost_d    = 1'b1;
            retries_d = 4'd0;
            dly_rst_d = 1'b1;
          end
        end
        S_FAILED: begin
          dly_rst_d = 1'b0;
        end
        default: begin
          state_d   = S_RESET_PULSE;
          cnt_d     = '0;
          dly_rst_d = 1'b1;
          ready_d   = 1'b0;
        end
      endcase
    end
  end

  // State, shared counter and registered outputs.
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      state_q   <= S_RESET_PULSE;
      cnt_q     <= '0;
      dly_rst_q <= 1'b1;
      ready_q   <= 1'b0;
      fail_q    <= 1'b0;
      lost_q    <= 1'b0;
      retries_q <= 4'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      dly_rst_q <= dly_rst_d;
      ready_q   <= ready_d;
      fail_q    <= fail_d;
      lost_q    <= lost_d;
      retries_q <= retries_d;
    end
  end

endmodule

// File: tb/tb_idelay_ctrl_seq.sv
// Purpose: scoreboard bench for idelay_ctrl_seq; expected output changes are queued with the edge they must appear on.
// Latency: each queued entry names the refclk edge count at which the output vector must change.
// Backpressure: none; stimulus runs on a fixed cycle schedule and never waits on the DUT.
module tb_idelay_ctrl_seq;

  logic       refclk;
  logic       rst;
  logic       restart;
  logic       dly_rdy;
  logic       dly_rst;
  logic       ready;
  logic       fail;
  logic       lost;
  logic [3:0] retries;

  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;

  typedef struct {
    int         cyc;
    logic [7:0] val;
    string      name;
  } exp_t;

  exp_t exp_q[$];

  idelay_ctrl_seq #(
    .RST_CYCLES(16),
    .WAIT_CYCLES(64),
    .SETTLE_CYCLES(32),
    .MAX_RETRIES(2)
  ) dut (
    .refclk (refclk),
    .rst    (rst),
    .restart(restart),
    .dly_rdy(dly_rdy),
    .dly_rst(dly_rst),
    .ready  (ready),
    .fail   (fail),
    .lost   (lost),
    .retries(retries)
  );

  initial begin
    refclk = 1'b0;
    forever #5 refclk = ~refclk;
  end

  // Edge counter: after posedge k, cyc == k.
  always @(posedge refclk) cyc <= cyc + 1;

  // Output vector: {dly_rst, ready, fail, lost, retries}.
  function automatic logic [7:0] outs_now();
    return {dly_rst, ready, fail, lost, retries};
  endfunction

  function automatic void expect_at(int c, logic [7:0] v, string nm);
    exp_t e;
    e.cyc  = c;
    e.val  = v;
    e.name = nm;
    exp_q.push_back(e);
  endfunction

  // Advance to 2 time units after posedge c.
  task automatic step_to(int c);
    while (cyc < c) begin
      @(posedge refclk);
      #2;
    end
  endtask

  // Monitor: every change of the output vector pops one expected entry.
  initial begin
    logic [7:0] prev;
    logic [7:0] cur;
    exp_t       e;
    bit         first;
    first = 1'b1;
    prev  = 8'h00;
    @(posedge refclk);
    #1;
    forever begin
      cur = outs_now();
      if (first || cur !== prev) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_change: at edge %0d got %02h, no change expected", cyc, cur);
        end else begin
          e = exp_q.pop_front();
          if (e.cyc != cyc || e.val !== cur) begin
            n_fail++;
            $display("FAIL %s: got %02h at edge %0d, required %02h at edge %0d",
                     e.name, cur, cyc, e.val, e.cyc);
          end
        end
      end
      first = 1'b0;
      prev  = cur;
      @(negedge refclk or posedge rst);
      #1;
    end
  end

  initial begin
    int c, d, s, g, c1, t, u, x, y, m;
    rst     = 1'b1;
    restart = 1'b0;
    dly_rdy = 1'b0;

    // Reset state, nominal bring-up.
    expect_at(1, 8'h80, "reset_state");
    step_to(2);
    rst = 1'b0;
    expect_at(18, 8'h00, "nominal_rst_fall");
    c = 28;
    expect_at(c + 35, 8'h40, "nominal_ready");
    step_to(c);
    dly_rdy = 1'b1;

    // One-cycle RDY drop while READY.
    d = c + 40;
    expect_at(d + 3,  8'h90, "loss_drop");
    expect_at(d + 19, 8'h10, "loss_rst_fall");
    expect_at(d + 52, 8'h50, "loss_reready");
    step_to(d);
    dly_rdy = 1'b0;
    step_to(d + 1);
    dly_rdy = 1'b1;

    // Restart clears lost and reruns bring-up.
    s = 130;
    expect_at(s + 1,  8'h80, "restart_clear");
    expect_at(s + 17, 8'h00, "restart_rst_fall");
    expect_at(s + 50, 8'h40, "restart_ready");
    step_to(s);
    restart = 1'b1;
    step_to(s + 1);
    restart = 1'b0;

    // Settle glitch: high 10, low 1, high.
    g = 190;
    expect_at(g + 1,  8'h80, "glitch_restart");
    expect_at(g + 17, 8'h00, "glitch_rst_fall");
    c1 = g + 20;
    expect_at(c1 + 46, 8'h40, "glitch_ready");
    step_to(g);
    restart = 1'b1;
    dly_rdy = 1'b0;
    step_to(g + 1);
    restart = 1'b0;
    step_to(c1);
    dly_rdy = 1'b1;
    step_to(c1 + 10);
    dly_rdy = 1'b0;
    step_to(c1 + 11);
    dly_rdy = 1'b1;

    // Timeout on first attempt, success on the second.
    t = 266;
    expect_at(t + 1,   8'h80, "tmo_restart");
    expect_at(t + 17,  8'h00, "tmo_rst_fall1");
    expect_at(t + 81,  8'h81, "tmo_retry_pulse");
    expect_at(t + 97,  8'h01, "tmo_rst_fall2");
    expect_at(t + 130, 8'h41, "tmo_ready");
    step_to(t);
    restart = 1'b1;
    dly_rdy = 1'b0;
    step_to(t + 1);
    restart = 1'b0;
    step_to(t + 86);
    dly_rdy = 1'b1;

    // RDY arriving on the timeout edge wins over the retry.
    u = 406;
    expect_at(u + 1,   8'h80, "race_restart");
    expect_at(u + 17,  8'h00, "race_rst_fall");
    expect_at(u + 113, 8'h40, "race_ready");
    step_to(u);
    restart = 1'b1;
    dly_rdy = 1'b0;
    step_to(u + 1);
    restart = 1'b0;
    step_to(u + 78);
    dly_rdy = 1'b1;

    // Exhaustion with RDY stuck low, then restart out of FAILED.
    x = 529;
    expect_at(x + 1,   8'h80, "exh_restart");
    expect_at(x + 17,  8'h00, "exh_fall1");
    expect_at(x + 81,  8'h81, "exh_pulse2");
    expect_at(x + 97,  8'h01, "exh_fall2");
    expect_at(x + 161, 8'h82, "exh_pulse3");
    expect_at(x + 177, 8'h02, "exh_fall3");
    expect_at(x + 241, 8'h22, "exh_fail");
    step_to(x);
    restart = 1'b1;
    dly_rdy = 1'b0;
    step_to(x + 1);
    restart = 1'b0;
    y = x + 300;
    expect_at(y + 1,  8'h80, "exh_restart_clear");
    expect_at(y + 17, 8'h00, "exh_restart_fall");
    step_to(y);
    restart = 1'b1;
    step_to(y + 1);
    restart = 1'b0;

    // Async reset in the middle of SETTLE.
    step_to(y + 20);
    dly_rdy = 1'b1;
    m = y + 30;
    expect_at(m,      8'h80, "arst_immediate");
    expect_at(m + 19, 8'h00, "arst_rst_fall");
    expect_at(m + 52, 8'h40, "arst_ready");
    step_to(m);
    rst = 1'b1;
    step_to(m + 3);
    rst = 1'b0;

    step_to(m + 70);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL pending_events: %0d expected changes never seen, required 0 (next %s at edge %0d)",
               exp_q.size(), exp_q[0].name, exp_q[0].cyc);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
